debounce_bank: RTL and testbench

//  Parametrised N-channel input conditioner for buttons and switches: per-channel synchroniser,

---
 rtl/debounce_pkg.sv | 20 ++
 rtl/debounce_chan.sv | 129 ++++++++++++
 rtl/debounce_bank.sv | 45 ++++
 tb/tb_debounce_bank.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// +-----------------------------------------------------------------------------+
// | debounce_pkg : shared width helper and default timing constants             |
// | Revision     : 1.0                                                          |
// +-----------------------------------------------------------------------------+
`default_nettype none

package debounce_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEFAULT_REPEAT_DELAY    = 50_000_000;
  localparam int unsigned DEFAULT_REPEAT_PERIOD   = 10_000_000;

  // One spare bit so a counter sized for n can never wrap while reaching n-1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_chan.sv
// +-----------------------------------------------------------------------------+
// | debounce_chan : one channel - synchroniser, debounce filter, edge strobes   |
// |                 and auto-repeat (auto-repeat built only with HOLD_REPEAT_EN)|
// | Revision      : 1.0                                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned NSYNC           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic noisy_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o,
  output logic repeat_o
);

  localparam int unsigned DW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] c_db_max = DW'(DEBOUNCE_CYCLES - 1);

  if (NSYNC < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("debounce_chan: illegal parameter value");
  end

  logic [NSYNC-1:0] sync_q;
  logic             sync_s;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic             clean_q, clean_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  assign sync_s = sync_q[NSYNC-1];

  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_s == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q == c_db_max) begin
      clean_d = sync_s;
      cnt_d   = '0;
      rise_d  = sync_s;
      fall_d  = ~sync_s;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[NSYNC-2:0], noisy_i};
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

`ifdef HOLD_REPEAT_EN
  localparam int unsigned HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HW   = cnt_w(HMAX);
  localparam logic [HW-1:0] c_delay_max  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] c_period_max = HW'(REPEAT_PERIOD - 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          first_q, first_d;
  logic          rep_q, rep_d;

  // hold counts cycles since the last strobe; first selects the initial delay.
  // Gating on clean_d drops any strobe that would land on the release cycle.
  always_comb begin
    hold_d  = hold_q;
    first_d = first_q;
    rep_d   = 1'b0;
    if (rise_d) begin
      hold_d  = '0;
      first_d = 1'b1;
      rep_d   = 1'b1;
    end else if (!clean_d) begin
      hold_d  = '0;
      first_d = 1'b0;
    end else if (hold_q == (first_q ? c_delay_max : c_period_max)) begin
      hold_d  = '0;
      first_d = 1'b0;
      rep_d   = 1'b1;
    end else begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold_q  <= '0;
      first_q <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      first_q <= first_d;
      rep_q   <= rep_d;
    end
  end

  assign repeat_o = rep_q;
`else
  assign repeat_o = rise_q;
`endif

endmodule

`default_nettype wire

// File: rtl/debounce_bank.sv
// +-----------------------------------------------------------------------------+
// | debounce_bank : N_CH independent input conditioners (HOLD_REPEAT_EN adds    |
// |                 auto-repeat on repeat_out)                                  |
// | Revision      : 1.0                                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH            = 8,
  parameter int unsigned NSYNC           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic [N_CH-1:0] noisy_in,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_out,
  output logic [N_CH-1:0] fall_out,
  output logic [N_CH-1:0] repeat_out
);

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    debounce_chan #(
      .NSYNC           (NSYNC),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan (
      .clk_i    (clk_in),
      .rst_n_i  (rst_n_in),
      .noisy_i  (noisy_in[g]),
      .clean_o  (clean_out[g]),
      .rise_o   (rise_out[g]),
      .fall_o   (fall_out[g]),
      .repeat_o (repeat_out[g])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: directed steps, bounces and a mid-count reset, then random
// per-channel hold times, all checked against a run-length / timestamp reference model.
`default_nettype none

module tb_debounce_bank;

  localparam int N_CH   = 4;
  localparam int NSYNC  = 3;
  localparam int DB     = 8;
  localparam int RDELAY = 20;
  localparam int RPER   = 5;

  logic            clk_in = 1'b0;
  logic            rst_n_in;
  logic [N_CH-1:0] noisy_in;
  logic [N_CH-1:0] clean_out, rise_out, fall_out, repeat_out;

  debounce_bank #(
    .N_CH            (N_CH),
    .NSYNC           (NSYNC),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RDELAY),
    .REPEAT_PERIOD   (RPER)
  ) dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .noisy_in   (noisy_in),
    .clean_out  (clean_out),
    .rise_out   (rise_out),
    .fall_out   (fall_out),
    .repeat_out (repeat_out)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  // Reference model: input sample history, mismatch run length, time of last rise.
  logic [N_CH-1:0] hist[$];
  int              run[N_CH];
  int              rise_t[N_CH];
  int              t;
  logic [N_CH-1:0] m_clean, m_rise, m_fall, m_rep;

  task automatic model_reset();
    hist.delete();
    t = 0;
    m_clean = '0; m_rise = '0; m_fall = '0; m_rep = '0;
    for (int c = 0; c < N_CH; c++) begin
      run[c] = 0;
      rise_t[c] = 0;
    end
  endtask

  task automatic model_edge(input logic [N_CH-1:0] smp);
    logic [N_CH-1:0] s;
    int d;
    s = (hist.size() == NSYNC) ? hist[0] : '0;
    hist.push_back(smp);
    if (hist.size() > NSYNC) void'(hist.pop_front());
    t++;
    m_rise = '0; m_fall = '0; m_rep = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (s[c] != m_clean[c]) begin
        run[c]++;
        if (run[c] == DB) begin
          m_clean[c] = s[c];
          run[c] = 0;
          if (s[c]) begin m_rise[c] = 1'b1; rise_t[c] = t; end
          else m_fall[c] = 1'b1;
        end
      end else begin
        run[c] = 0;
      end
`ifdef HOLD_REPEAT_EN
      d = t - rise_t[c];
      m_rep[c] = m_clean[c] && (d == 0 || (d >= RDELAY && ((d - RDELAY) % RPER) == 0));
`else
      d = 0;
      m_rep[c] = m_rise[c];
`endif
    end
  endtask

  task automatic check();
    checks++;
    assert (clean_out === m_clean) else begin
      failures++; $error("FAIL clean t=%0d observed=%b expected=%b", t, clean_out, m_clean);
    end
    checks++;
    assert (rise_out === m_rise) else begin
      failures++; $error("FAIL rise t=%0d observed=%b expected=%b", t, rise_out, m_rise);
    end
    checks++;
    assert (fall_out === m_fall) else begin
      failures++; $error("FAIL fall t=%0d observed=%b expected=%b", t, fall_out, m_fall);
    end
    checks++;
    assert (repeat_out === m_rep) else begin
      failures++; $error("FAIL repeat t=%0d observed=%b expected=%b", t, repeat_out, m_rep);
    end
  endtask

  // One clock: model follows the DUT edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk_in);
    if (rst_n_in) model_edge(noisy_in);
    @(negedge clk_in);
    check();
  endtask

  task automatic pulse_reset();
    rst_n_in = 1'b0;
    #1;
    model_reset();
    check();
    @(posedge clk_in);
    @(negedge clk_in);
    check();
    rst_n_in = 1'b1;
  endtask

  int hold_left[N_CH];
  int bounce[13] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 0};

  initial begin
    rst_n_in = 1'b0;
    noisy_in = '0;
    model_reset();
    @(negedge clk_in);
    check();
    @(negedge clk_in);
    check();
    rst_n_in = 1'b1;

    // ch0 and ch3 step together; reset strikes mid-count, input stays high.
    noisy_in = 4'b1001;
    for (int i = 0; i < 6; i++) cycle();
    pulse_reset();
    for (int i = 0; i < 45; i++) cycle();

    // ch1 bounces and never settles high long enough.
    for (int i = 0; i < 13; i++) begin
      noisy_in[1] = bounce[i][0];
      cycle();
    end
    for (int i = 0; i < 15; i++) cycle();

    // ch2 held then released; ch3 released between repeat strobes.
    noisy_in[2] = 1'b1;
    for (int i = 0; i < 40; i++) cycle();
    noisy_in[2] = 1'b0;
    noisy_in[3] = 1'b0;
    for (int i = 0; i < 25; i++) cycle();

    // Random hold lengths: mostly short glitches, some long presses.
    for (int c = 0; c < N_CH; c++) hold_left[c] = 1;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        hold_left[c]--;
        if (hold_left[c] <= 0) begin
          noisy_in[c] = ~noisy_in[c];
          hold_left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 90))
                                                     : int'($urandom_range(1, 12));
        end
      end
      if (i == 1500) pulse_reset();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
